hawk_decomp_pgwr: RTL

HAWK_DECOMP_PGWR -- requirements
Module: hawk_decomp_pgwr

---
 rtl/hacd_pkg.sv | 28 ++
 rtl/hawk_axi_wr_otrk.sv | 39 +++
 rtl/hawk_decomp_pgwr.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hacd_pkg.sv
// Shared widths, page-writer state encoding and progress record for the HACD decompressor path.
package hacd_pkg;

  localparam int HACD_AXI4_ADDR_WIDTH     = 64;
  localparam int HACD_AXI4_DATA_WIDTH     = 512;
  localparam int HACD_AXI4_RESP_WIDTH     = 2;
  localparam int HACD_PGWR_LINES_PER_PAGE = 64;

  typedef enum logic [2:0] {
    PGWR_IDLE,
    PGWR_ISSUE,
    PGWR_DRAIN,
    PGWR_DONE,
    PGWR_BUS_ERROR
  } pgwr_state_t;

  typedef struct packed {
    logic [6:0] lines;
    logic       aw_pend;
    logic       w_pend;
  } pgwr_dbg_t;

  // Byte offset of a 64 B line inside a 4 KB page; the result never exceeds bit 11.
  function automatic logic [11:0] line_offset(input logic [5:0] line);
    return {line, 6'b0};
  endfunction

endpackage

// File: rtl/hawk_axi_wr_otrk.sv
// Outstanding AXI write tracker: up on AW handshake, down on B handshake, 1-cycle registered flags.
// Decrement saturates at zero so a response from an abandoned page cannot wrap the count.
module hawk_axi_wr_otrk #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] cnt;
  logic          dec_ok;

  assign dec_ok = dec && (cnt != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      case ({inc, dec_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign full  = (cnt == CW'(MAX_OUTSTANDING));
  assign empty = (cnt == '0);

endmodule

// File: rtl/hawk_decomp_pgwr.sv
// Writes one decompressed 4 KB page as single-beat AXI writes; first AW 2 cycles after start, one line per pair.
// Stalls the line stream while an AW/W pair is pending or MAX_OUTSTANDING writes await B; HAWK_PGWR_ZERO_SKIP_EN skips all-zero lines.
module hawk_decomp_pgwr
  import hacd_pkg::*;
#(
  parameter int LINES_PER_PAGE  = HACD_PGWR_LINES_PER_PAGE,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              pgwr_start,
  input  logic [HACD_AXI4_ADDR_WIDTH-1:0]   pgwr_dst_addr,
  input  logic                              pgwr_soft_rst,
  input  logic                              dline_valid,
  output logic                              dline_ready,
  input  logic [HACD_AXI4_DATA_WIDTH-1:0]   dline_data,
  output logic                              awvalid,
  input  logic                              awready,
  output logic [HACD_AXI4_ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]                        awlen,
  output logic                              wvalid,
  input  logic                              wready,
  output logic [HACD_AXI4_DATA_WIDTH-1:0]   wdata,
  output logic [HACD_AXI4_DATA_WIDTH/8-1:0] wstrb,
  output logic                              wlast,
  input  logic                              bvalid,
  output logic                              bready,
  input  logic [HACD_AXI4_RESP_WIDTH-1:0]   bresp,
  output logic                              pgwr_done,
  output logic                              pgwr_err,
  output logic                              pgwr_busy,
  output logic [6:0]                        pgwr_dbg_lines
`ifdef HAWK_PGWR_ZERO_SKIP_EN
  ,
  output logic [6:0]                        pgwr_zero_cnt
`endif
);

  localparam logic [HACD_AXI4_ADDR_WIDTH-1:0] PAGE_MASK = HACD_AXI4_ADDR_WIDTH'(12'hFFF);

  pgwr_state_t                     state, state_nxt;
  pgwr_dbg_t                       prog;
  logic [HACD_AXI4_ADDR_WIDTH-1:0] base_q, awaddr_q;
  logic [HACD_AXI4_DATA_WIDTH-1:0] wdata_q;
  logic                            err_q;
  logic                            otrk_full, otrk_empty;
  logic                            start_acc, line_acc, line_zero, pair_idle;
  logic                            aw_hs, w_hs, b_hs, b_err;

  assign pair_idle = !prog.aw_pend && !prog.w_pend;
  assign start_acc = (state == PGWR_IDLE) && pgwr_start && !pgwr_done;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign b_err     = b_hs && (bresp != '0);
  assign line_acc  = dline_valid && dline_ready;

`ifdef HAWK_PGWR_ZERO_SKIP_EN
  assign line_zero = (dline_data == '0);
`else
  assign line_zero = 1'b0;
`endif

  assign dline_ready = (state == PGWR_ISSUE) && pair_idle && !otrk_full &&
                       (prog.lines < 7'(LINES_PER_PAGE));

  hawk_axi_wr_otrk #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_otrk (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr   (pgwr_soft_rst || start_acc),
    .inc   (aw_hs),
    .dec   (b_hs),
    .full  (otrk_full),
    .empty (otrk_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= PGWR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      PGWR_IDLE:      if (start_acc) state_nxt = PGWR_ISSUE;
      PGWR_ISSUE: begin
        if (b_err) state_nxt = PGWR_BUS_ERROR;
        else if ((prog.lines == 7'(LINES_PER_PAGE)) && pair_idle) state_nxt = PGWR_DRAIN;
      end
      PGWR_DRAIN: begin
        if (b_err) state_nxt = PGWR_BUS_ERROR;
        else if (otrk_empty) state_nxt = PGWR_DONE;
      end
      PGWR_DONE:      state_nxt = PGWR_IDLE;
      PGWR_BUS_ERROR: state_nxt = PGWR_BUS_ERROR;
      default:        state_nxt = PGWR_IDLE;
    endcase
    if (pgwr_soft_rst) state_nxt = PGWR_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog     <= '0;
      base_q   <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef HAWK_PGWR_ZERO_SKIP_EN
      pgwr_zero_cnt <= '0;
`endif
    end else begin
      if (b_err) err_q <= 1'b1;
      if (pgwr_soft_rst) begin
        prog <= '0;
`ifdef HAWK_PGWR_ZERO_SKIP_EN
        pgwr_zero_cnt <= '0;
`endif
      end else if (start_acc) begin
        prog   <= '0;
        base_q <= pgwr_dst_addr & ~PAGE_MASK;
`ifdef HAWK_PGWR_ZERO_SKIP_EN
        pgwr_zero_cnt <= '0;
`endif
      end else begin
        if (aw_hs) prog.aw_pend <= 1'b0;
        if (w_hs)  prog.w_pend  <= 1'b0;
        if (line_acc) begin
          prog.lines <= prog.lines + 7'd1;
          if (line_zero) begin
`ifdef HAWK_PGWR_ZERO_SKIP_EN
            pgwr_zero_cnt <= pgwr_zero_cnt + 7'd1;
`endif
          end else begin
            // Offset is OR'd in: the base is page aligned, so no carry into the page number.
            prog.aw_pend <= 1'b1;
            prog.w_pend  <= 1'b1;
            awaddr_q     <= base_q | {{(HACD_AXI4_ADDR_WIDTH-12){1'b0}}, line_offset(prog.lines[5:0])};
            wdata_q      <= dline_data;
          end
        end
      end
    end
  end

  assign awvalid        = prog.aw_pend;
  assign wvalid         = prog.w_pend;
  assign awaddr         = awaddr_q;
  assign awlen          = 8'd0;
  assign wdata          = wdata_q;
  assign wstrb          = '1;
  assign wlast          = 1'b1;
  assign bready         = (state != PGWR_IDLE);
  assign pgwr_done      = (state == PGWR_DONE);
  assign pgwr_err       = err_q;
  assign pgwr_busy      = (state != PGWR_IDLE);
  assign pgwr_dbg_lines = prog.lines;

endmodule
